// File: rtl/mbist_pkg.sv
// Shared types and March C- element tables for the MBIST controller.
// Element tables are 8 bits wide so indexing with any 3-bit element code stays in range.
package mbist_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PREP,
    ST_M0,
    ST_M1,
    ST_M2,
    ST_M3,
    ST_M4,
    ST_M5,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [2:0] ELEM_M0 = 3'd0;
  localparam logic [2:0] ELEM_M1 = 3'd1;
  localparam logic [2:0] ELEM_M2 = 3'd2;
  localparam logic [2:0] ELEM_M3 = 3'd3;
  localparam logic [2:0] ELEM_M4 = 3'd4;
  localparam logic [2:0] ELEM_M5 = 3'd5;

  // Bit e of each table describes element Me.
  localparam logic [7:0] ELEM_DOWN   = 8'b0001_1000;  // M3, M4 descend
  localparam logic [7:0] ELEM_TWO_OP = 8'b0001_1110;  // M1..M4 are (read, write)
  localparam logic [7:0] ELEM_RD_BG  = 8'b0001_0100;  // M2, M4 read all-ones
  localparam logic [7:0] ELEM_WR_BG  = 8'b0000_1010;  // M1, M3 write all-ones

  localparam int OPS_PER_ADDR = 10;

  function automatic logic is_elem_state(state_e s);
    return (s >= ST_M0) && (s <= ST_M5);
  endfunction

  function automatic logic [2:0] state_elem(state_e s);
    return 3'(4'(s) - 4'(ST_M0));
  endfunction

  function automatic logic op_is_write(logic [2:0] e, logic op);
    return ELEM_TWO_OP[e] ? op : (e == ELEM_M0);
  endfunction

endpackage

// File: rtl/mbist_checker.sv
// Read-data checker: 2-deep expected/valid pipeline aligned to memory read latency,
// comparator, saturating error counter and first-failure capture.
module mbist_checker
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  issue_vld,
  input  logic [DATA_WIDTH-1:0] issue_exp,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  logic [2:0]            issue_elem,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  fail,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_syn
);

  logic [1:0]            vld_q;
  logic [DATA_WIDTH-1:0] exp_q1, exp_q2;
  logic [ADDR_WIDTH-1:0] addr_q1, addr_q2;
  logic [2:0]            elem_q1, elem_q2;
  logic [DATA_WIDTH-1:0] syn;
  logic                  mismatch;

  assign syn      = rdata ^ exp_q2;
  assign mismatch = vld_q[1] && (syn != '0);

  // NOTE: only the valid bits need a reset; payload stages are ignored until
  // their valid bit is set, so they are left unreset like a RAM would be.
  always_ff @(posedge clk) begin
    exp_q1  <= issue_exp;
    exp_q2  <= exp_q1;
    addr_q1 <= issue_addr;
    addr_q2 <= addr_q1;
    elem_q1 <= issue_elem;
    elem_q2 <= elem_q1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      fail      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_syn  <= '0;
    end else begin
      vld_q <= {vld_q[0], issue_vld};
      if (clear) begin
        fail      <= 1'b0;
        err_count <= '0;
        fail_addr <= '0;
        fail_elem <= '0;
        fail_syn  <= '0;
      end else if (mismatch) begin
        fail <= 1'b1;
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (!fail) begin
          fail_addr <= addr_q2;
          fail_elem <= elem_q2;
          fail_syn  <= syn;
        end
      end
    end
  end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller: FSM plus address/op generator driving registered
// memory commands, with read checking delegated to mbist_checker.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int          DATA_WIDTH = 8,
  parameter int          ADDR_WIDTH = 3,
  parameter int unsigned LAST_ADDR  = (1 << ADDR_WIDTH) - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  write_read,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_syn
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LAST_ADDR);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, term_d;
  logic                  op_q, op_d;
  logic [2:0]            elem, elem_d;
  logic                  at_term, last_op, in_elem_d, accept;
  logic                  wr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic                  rd_vld_q;
  logic [DATA_WIDTH-1:0] rd_exp_q;
  logic [2:0]            rd_elem_q;

  assign accept = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign busy   = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done   = (state_q == ST_DONE);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    op_d    = op_q;
    elem    = state_elem(state_q);
    at_term = ELEM_DOWN[elem] ? (addr_q == '0) : (addr_q == LAST);
    last_op = !ELEM_TWO_OP[elem] || op_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_PREP;
          addr_d  = '0;
          op_d    = 1'b0;
        end
      end
      ST_PREP: begin
        state_d = ST_M0;
        addr_d  = '0;
        op_d    = 1'b0;
      end
      ST_DRAIN: begin
        op_d = 1'b1;
        if (op_q) begin
          state_d = ST_DONE;
          op_d    = 1'b0;
        end
      end
      default: begin
        if (!last_op) begin
          op_d = 1'b1;
        end else begin
          op_d = 1'b0;
          if (at_term) begin
            // Counters never wrap: the terminal address hands over to the next element.
            state_d = state_e'(4'(state_q) + 4'd1);
            addr_d  = ELEM_DOWN[3'(elem + 3'd1)] ? LAST : '0;
          end else begin
            addr_d = ELEM_DOWN[elem] ? addr_q - 1'b1 : addr_q + 1'b1;
          end
        end
      end
    endcase

    // Command for the next cycle; wdata runs one op ahead of its write.
    elem_d    = state_elem(state_d);
    in_elem_d = is_elem_state(state_d);
    term_d    = ELEM_DOWN[elem_d] ? '0 : LAST;
    wr_d      = in_elem_d && op_is_write(elem_d, op_d);
    wdata_d   = wdata;
    if (state_d == ST_PREP) begin
      wdata_d = '0;
    end else if (in_elem_d) begin
      if (ELEM_TWO_OP[elem_d] && !op_d)
        wdata_d = {DATA_WIDTH{ELEM_WR_BG[elem_d]}};
      else if (!ELEM_TWO_OP[elem_d] && op_is_write(elem_d, 1'b0) && addr_d != term_d)
        wdata_d = {DATA_WIDTH{ELEM_WR_BG[elem_d]}};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      op_q       <= 1'b0;
      write_read <= 1'b0;
      address    <= '0;
      wdata      <= '0;
      rd_vld_q   <= 1'b0;
      rd_exp_q   <= '0;
      rd_elem_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      op_q       <= op_d;
      write_read <= wr_d;
      address    <= in_elem_d ? addr_d : '0;
      wdata      <= wdata_d;
      rd_vld_q   <= in_elem_d && !wr_d;
      rd_exp_q   <= {DATA_WIDTH{ELEM_RD_BG[elem_d]}};
      rd_elem_q  <= elem_d;
    end
  end

  mbist_checker #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_checker (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .issue_vld (rd_vld_q),
    .issue_exp (rd_exp_q),
    .issue_addr(address),
    .issue_elem(rd_elem_q),
    .rdata     (rdata),
    .fail      (fail),
    .err_count (err_count),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .fail_syn  (fail_syn)
  );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl with a behavioural memory model that can
// inject a stuck-at or a coupling fault.
module tb_mbist_march_ctrl;
  import mbist_pkg::*;

  localparam int DW      = 8;
  localparam int AW      = 3;
  localparam int N       = 1 << AW;
  localparam int DONE_AT = OPS_PER_ADDR * N + 4;
  localparam int MAX_CYC = 300;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          write_read;
  logic [AW-1:0] address;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          busy, done, fail;
  logic [15:0]   err_count;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] fail_syn;

  int checks = 0;
  int errors = 0;
  int fault_mode = 0;  // 0 none, 1 addr4 bit5 stuck-at-1, 2 coupling on addr5 from addr4

  always #5 clk = ~clk;

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .write_read(write_read),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .err_count (err_count),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .fail_syn  (fail_syn)
  );

  // Memory model: wdata registered once, read data through two register stages.
  logic [DW-1:0] mem [N];
  logic [DW-1:0] wd_q, rd1;

  function automatic logic [DW-1:0] mem_read_val(logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = mem[a];
    if (fault_mode == 1 && a == 3'd4) v[5] = 1'b1;
    return v;
  endfunction

  function automatic logic [DW-1:0] mem_write_val(logic [AW-1:0] a, logic [DW-1:0] d);
    logic [DW-1:0] v;
    v = d;
    if (fault_mode == 2 && a == 3'd5 && mem[4][5]) v[5] = mem[5][5];
    return v;
  endfunction

  always @(posedge clk) begin
    wd_q <= wdata;
    if (write_read) mem[address] <= mem_write_val(address, wd_q);
    rd1   <= mem_read_val(address);
    rdata <= rd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " write_read"}, 32'(write_read), 0);
    check({tag, " address"},    32'(address),    0);
    check({tag, " wdata"},      32'(wdata),      0);
    check({tag, " busy"},       32'(busy),       0);
    check({tag, " done"},       32'(done),       0);
    check({tag, " fail"},       32'(fail),       0);
    check({tag, " err_count"},  32'(err_count),  0);
    check({tag, " fail_addr"},  32'(fail_addr),  0);
    check({tag, " fail_elem"},  32'(fail_elem),  0);
    check({tag, " fail_syn"},   32'(fail_syn),   0);
  endtask

  // Starts a run (start sampled at the end of cycle 0) and samples at each
  // negedge of cycle c. Returns the first cycle with done=1, 0 on abort, -1 on timeout.
  task automatic run_test(input string tag, input int abort_at, input int restart_at,
                          input bit trace, output int done_cyc);
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= MAX_CYC; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        check({tag, " c1 busy"},      32'(busy),      1);
        check({tag, " c1 done"},      32'(done),      0);
        check({tag, " c1 fail"},      32'(fail),      0);
        check({tag, " c1 err_count"}, 32'(err_count), 0);
      end
      if (trace) begin
        if (c == 1) begin
          check({tag, " c1 wdata"},      32'(wdata),      0);
          check({tag, " c1 write_read"}, 32'(write_read), 0);
          check({tag, " c1 address"},    32'(address),    0);
        end
        if (c == 2) begin
          check({tag, " c2 write_read"}, 32'(write_read), 1);
          check({tag, " c2 address"},    32'(address),    0);
        end
        if (c == 9) begin
          check({tag, " c9 write_read"}, 32'(write_read), 1);
          check({tag, " c9 address"},    32'(address),    7);
        end
        if (c == 10) begin
          check({tag, " c10 write_read"}, 32'(write_read), 0);
          check({tag, " c10 address"},    32'(address),    0);
        end
        if (c == DONE_AT - 1) begin
          check({tag, " last busy"}, 32'(busy), 1);
          check({tag, " last done"}, 32'(done), 0);
        end
      end
      if (c == restart_at) start = 1'b1;
      if (c == restart_at + 1) start = 1'b0;
      if (done) begin
        done_cyc = c;
        break;
      end
      if (c == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check_reset_values({tag, " abort"});
        rst = 1'b0;
        done_cyc = 0;
        break;
      end
    end
  endtask

  initial begin
    int dc;
    for (int i = 0; i < N; i++) mem[i] = '0;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // Fault-free run with command trace.
    fault_mode = 0;
    run_test("clean", -1, -1, 1'b1, dc);
    check("clean done cycle", 32'(dc), 32'(DONE_AT));
    check("clean fail", 32'(fail), 0);
    check("clean err_count", 32'(err_count), 0);
    check("clean busy after", 32'(busy), 0);

    // Stuck-at-1 on bit 5 of address 4.
    fault_mode = 1;
    run_test("stuck", -1, -1, 1'b0, dc);
    check("stuck done cycle", 32'(dc), 32'(DONE_AT));
    check("stuck fail", 32'(fail), 1);
    check("stuck err_count", 32'(err_count), 3);
    check("stuck fail_addr", 32'(fail_addr), 4);
    check("stuck fail_elem", 32'(fail_elem), 1);
    check("stuck fail_syn", 32'(fail_syn), 32'h20);

    // Abort with rst at cycle 40, then a clean run from IDLE.
    fault_mode = 0;
    run_test("abort", 40, -1, 1'b0, dc);
    check("abort returned", 32'(dc), 0);
    run_test("after_abort", -1, -1, 1'b0, dc);
    check("after_abort done cycle", 32'(dc), 32'(DONE_AT));
    check("after_abort fail", 32'(fail), 0);

    // start pulsed while busy is ignored.
    run_test("restart", -1, 30, 1'b0, dc);
    check("restart done cycle", 32'(dc), 32'(DONE_AT));
    check("restart fail", 32'(fail), 0);
    check("restart err_count", 32'(err_count), 0);

    // Coupling fault: victim addr 5 keeps old bit 5 while addr 4 bit 5 is 1.
    fault_mode = 2;
    run_test("coupling", -1, -1, 1'b0, dc);
    check("coupling done cycle", 32'(dc), 32'(DONE_AT));
    check("coupling fail", 32'(fail), 1);
    check("coupling fail_syn", 32'(fail_syn), 32'h20);
    check("coupling fail_addr", 32'(fail_addr), 5);
    check("coupling fail_elem", 32'(fail_elem), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mbist_march_ctrl.md
# mbist_march_ctrl

March C- MBIST controller that sits directly upstream of the fault-injected memory model (`fault_mem`). On a start request it generates the full write/read/address/wdata command stream for March C- over every address. It checks each returned `rdata` against the expected background and reports pass/fail with first-failure diagnostics. All memory-facing timing matches the memory model: write data is registered once inside the memory, and read data has two register stages.

## Interface
Parameters:
- `DATA_WIDTH`, 8: memory word width.
- `ADDR_WIDTH`, 3: memory address width.
- `LAST_ADDR`, (1<<ADDR_WIDTH)-1: highest address tested; the sweep covers 0..`LAST_ADDR`, N = `LAST_ADDR`+1.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin test; sampled only in IDLE or DONE.
- `write_read`  out  1: 1 = write, 0 = read; to memory.
- `address`  out  ADDR_WIDTH: to memory.
- `wdata`  out  DATA_WIDTH: to memory; leads its write command by one cycle.
- `rdata`  in  DATA_WIDTH: from memory.
- `busy`  out  1: test in progress.
- `done`  out  1: level; test finished, held until next accepted `start`.
- `fail`  out  1: at least one mismatch seen in the current run.
- `err_count`  out  16: number of mismatching reads, saturating at 16'hFFFF.
- `fail_addr`  out  ADDR_WIDTH: address of the first mismatch.
- `fail_elem`  out  3: March element index (0-5) of the first mismatch.
- `fail_syn`  out  DATA_WIDTH: `rdata` XOR expected at the first mismatch.

## Operation
- Algorithm: M0 ⇕(w0); M1 ⇑(r0,w1); M2 ⇑(r1,w0); M3 ⇓(r0,w1); M4 ⇓(r1,w0); M5 ⇕(r0).
  - 0 means all-zeros and 1 means all-ones of DATA_WIDTH.
  - ⇕ elements run ascending.
  - The sequence totals 10N ops.
- FSM states: IDLE → PREP → M0 → M1 → M2 → M3 → M4 → M5 → DRAIN → DONE.
  - IDLE/DONE → PREP when `start`=1.
  - PREP lasts 1 cycle. It drives `wdata` for the first op, with `write_read`=0 and `address`=0.
  - Each Mk advances to the next state after its last op at its terminal address (`LAST_ADDR` going up, 0 going down).
  - In two-op elements, the address steps only after the second op.
  - DRAIN lasts 2 cycles so the final reads complete, then the FSM enters DONE.
- Command outputs are registered. During each op cycle, `wdata` carries the data of the next op's write, or holds its value if the next op is a read.
- Compare path:
  - A read issued in cycle n returns `rdata` valid in cycle n+2.
  - Expected data, address and element travel in a 2-deep shift register alongside a valid bit.
  - The compare happens at the end of cycle n+2.
- On a mismatch:
  - Set `fail` and increment `err_count`.
  - Capture `fail_addr`, `fail_elem` and `fail_syn` only if `fail` was previously 0.
  - The test always runs to completion.
- Accepting `start` clears `fail`, `err_count`, the `fail_*` outputs and `done`, and sets `busy`.
- `start` while busy is ignored.

## Timing
- Reset values: `write_read`=0, `address`=0, `wdata`=0, `busy`=0, `done`=0, `fail`=0, `err_count`=0, `fail_addr`=0, `fail_elem`=0, `fail_syn`=0. State is IDLE.
- `rst` mid-run aborts immediately to the reset values. In-flight compares are discarded via the cleared valid bits.
- Run timeline, with `start` sampled at the end of cycle 0:
  - Cycle 1 is PREP.
  - Ops occupy cycles 2..10N+1.
  - The last compare happens at the end of cycle 10N+3.
  - `done`=1 and `busy`=0 from cycle 10N+4.
- `busy` is 1 from cycle 1 through cycle 10N+3.
- Boundary handling:
  - Element turnarounds at the same address (M2 end → M3 start at `LAST_ADDR`) require no bubble. The memory writes one edge before it samples the read.
  - Address counters never wrap; the terminal address triggers the element change.
  - A read followed by a write at the same address in consecutive cycles returns the pre-write value.

## Structure
- Package `mbist_pkg` holds:
  - the state enum;
  - the element index constants;
  - per-element op table constants (direction, op count, read/write background);
  - the localparam total op count.
- Sub-module `mbist_checker` holds the 2-stage expected/valid pipeline, the comparator, the saturating error counter and the first-fail capture.
- The top level keeps the FSM and the address/op generator.

## Test plan
- Fault-free memory model with `ADDR_WIDTH`=3 → `done` rises in cycle 84 after start, with `fail`=0 and `err_count`=0.
- Trace check on the same run:
  - cycle 2 shows `write_read`=1 at `address`=0, with `wdata`=0 during cycle 1;
  - the first read (M1, addr 0) appears in cycle 10.
- Bit 5 of addr 4 forced stuck-at-1 → first mismatch `fail_addr`=4, `fail_elem`=1, `fail_syn`=8'h20, `fail`=1, `err_count`=3 (M1, M3, M5).
- `rst` asserted at cycle 40 of a run → the next cycle shows all outputs at reset values. A new `start` then completes normally in 84 cycles.
- `start` pulsed again at cycle 30 while busy → ignored; `done` still rises in cycle 84.
- Coupling-fault memory variant (a write to the victim cell keeps the old bit 5 when the neighbour pattern matches) → `fail`=1 and `fail_syn`=8'h20 at the victim address.
